// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: pulls an opcode plus its extension words off MDB
// and hands the assembled instruction to decode over a valid/ready handshake.
module instr_fetch_seq #(
  parameter int DATA_W  = 16,
  parameter bit CG_EN   = 1'b1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MDB_out,
  input  logic              mdb_valid,
  input  logic              flush,
  input  logic              instr_ready,
  output logic              fetch_req,
  output logic              pc_inc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] ext_src,
  output logic [DATA_W-1:0] ext_dst,
  output logic [1:0]        FORMAT,
  output logic [2:0]        AdAs,
  output logic [1:0]        n_ext,
  output logic              illegal,
  output logic              fetch_to
);

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_SRC,
    FETCH_DST,
    ISSUE
  } state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] dst_q;
  logic [1:0]        fmt_q;
  logic [2:0]        adas_q;
  logic [1:0]        n_q;
  logic              dst_need_q;
  logic              ill_q;
  logic              to_q;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_d;
  logic              to_d;

  logic       accept;
  logic [1:0] fmt_w;
  logic [3:0] sr_w;
  logic [1:0] as_w;
  logic       ad_w;
  logic       src_w;
  logic       dst_w;
  logic [2:0] adas_w;

  assign fetch_req   = (state_q != ISSUE);
  assign accept      = fetch_req & mdb_valid & ~flush;
  assign pc_inc      = accept;
  assign instr_valid = (state_q == ISSUE);
  assign IR          = ir_q;
  assign ext_src     = src_q;
  assign ext_dst     = dst_q;
  assign FORMAT      = fmt_q;
  assign AdAs        = adas_q;
  assign n_ext       = n_q;
  assign illegal     = ill_q;
  assign fetch_to    = to_q;

  // Opcode classification is done on the raw MDB word so the FSM can branch
  // in the same cycle the opcode is accepted.
  always_comb begin
    fmt_w = 2'd0;
    unique case (1'b1)
      MDB_out[15:13] == 3'b001:  fmt_w = 2'd3;
      MDB_out[15:12] == 4'b0001: fmt_w = 2'd2;
      MDB_out[15:14] != 2'b00:   fmt_w = 2'd1;
      default:                   fmt_w = 2'd0;
    endcase
    as_w  = MDB_out[5:4];
    ad_w  = MDB_out[7];
    sr_w  = (fmt_w == 2'd2) ? MDB_out[3:0] : MDB_out[11:8];
    src_w = ((fmt_w == 2'd1) || (fmt_w == 2'd2)) &&
            (((as_w == 2'b01) && !(CG_EN && (sr_w == 4'd3))) ||
             ((as_w == 2'b11) && (sr_w == 4'd0)));
    dst_w = (fmt_w == 2'd1) && ad_w;
    adas_w = 3'b000;
    if (fmt_w == 2'd1) adas_w = {ad_w, as_w};
    if (fmt_w == 2'd2) adas_w = {1'b0, as_w};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_OP;
      ir_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      fmt_q      <= 2'd0;
      adas_q     <= 3'd0;
      n_q        <= 2'd0;
      dst_need_q <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      if (flush) begin
        state_q <= FETCH_OP;
      end else begin
        unique case (state_q)
          FETCH_OP: if (accept) begin
            ir_q       <= MDB_out;
            src_q      <= '0;
            dst_q      <= '0;
            n_q        <= 2'd0;
            fmt_q      <= fmt_w;
            adas_q     <= adas_w;
            dst_need_q <= dst_w;
            if (fmt_w == 2'd0) ill_q <= 1'b1;
            else if (src_w)    state_q <= FETCH_SRC;
            else if (dst_w)    state_q <= FETCH_DST;
            else               state_q <= ISSUE;
          end
          FETCH_SRC: if (accept) begin
            src_q   <= MDB_out;
            n_q     <= n_q + 2'd1;
            state_q <= dst_need_q ? FETCH_DST : ISSUE;
          end
          FETCH_DST: if (accept) begin
            dst_q   <= MDB_out;
            n_q     <= n_q + 2'd1;
            state_q <= ISSUE;
          end
          ISSUE: if (instr_ready) state_q <= FETCH_OP;
          default: state_q <= FETCH_OP;
        endcase
      end
    end
  end

  // Watchdog: only stalled fetch cycles count; any progress restarts it.
  always_comb begin
    wd_d = '0;
    to_d = 1'b0;
    if ((TIMEOUT != 0) && fetch_req && !mdb_valid && !flush) begin
      if (wd_q == WD_MAX) to_d = 1'b1;
      else                wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: scoreboard of issued instructions,
// plus flush, illegal, watchdog, reset and constant-generator cases.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] MDB_out;
  logic        mdb_valid;
  logic        flush;
  logic        instr_ready;
  logic        fetch_req;
  logic        pc_inc;
  logic        instr_valid;
  logic [15:0] IR;
  logic [15:0] ext_src;
  logic [15:0] ext_dst;
  logic [1:0]  FORMAT;
  logic [2:0]  AdAs;
  logic [1:0]  n_ext;
  logic        illegal;
  logic        fetch_to;

  logic [15:0] mdb1;
  logic        v1;
  logic        rdy1;
  logic        fetch_req1;
  logic        pc_inc1;
  logic        instr_valid1;
  logic [15:0] IR1;
  logic [15:0] ext_src1;
  logic [15:0] ext_dst1;
  logic [1:0]  FORMAT1;
  logic [2:0]  AdAs1;
  logic [1:0]  n_ext1;
  logic        illegal1;
  logic        fetch_to1;

  always #5 clk = ~clk;

  instr_fetch_seq #(.DATA_W(16), .CG_EN(1'b1), .TIMEOUT(15)) u0 (
    .clk(clk), .rst(rst), .MDB_out(MDB_out), .mdb_valid(mdb_valid),
    .flush(flush), .instr_ready(instr_ready), .fetch_req(fetch_req),
    .pc_inc(pc_inc), .instr_valid(instr_valid), .IR(IR),
    .ext_src(ext_src), .ext_dst(ext_dst), .FORMAT(FORMAT), .AdAs(AdAs),
    .n_ext(n_ext), .illegal(illegal), .fetch_to(fetch_to)
  );

  instr_fetch_seq #(.DATA_W(16), .CG_EN(1'b0), .TIMEOUT(15)) u1 (
    .clk(clk), .rst(rst), .MDB_out(mdb1), .mdb_valid(v1),
    .flush(1'b0), .instr_ready(rdy1), .fetch_req(fetch_req1),
    .pc_inc(pc_inc1), .instr_valid(instr_valid1), .IR(IR1),
    .ext_src(ext_src1), .ext_dst(ext_dst1), .FORMAT(FORMAT1), .AdAs(AdAs1),
    .n_ext(n_ext1), .illegal(illegal1), .fetch_to(fetch_to1)
  );

  typedef struct {
    logic [15:0] ir;
    logic [15:0] src;
    logic [15:0] dst;
    logic [1:0]  fmt;
    logic [2:0]  adas;
    logic [1:0]  n;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] ir, input logic [15:0] src,
                      input logic [15:0] dst, input logic [1:0] fmt,
                      input logic [2:0] adas, input logic [1:0] n);
    exp_t e;
    e.ir = ir; e.src = src; e.dst = dst;
    e.fmt = fmt; e.adas = adas; e.n = n;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [15:0] w);
    @(negedge clk);
    MDB_out = w;
    mdb_valid = 1'b1;
    #1 chk("pc_inc", {31'd0, pc_inc}, 32'd1);
  endtask

  task automatic issue(input string tag);
    exp_t e;
    @(negedge clk);
    mdb_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_req"}, {31'd0, fetch_req}, 32'd0);
    chk({tag, "_sb"}, {31'd0, sbq.size() != 0}, 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_IR"}, {16'd0, IR}, {16'd0, e.ir});
      chk({tag, "_src"}, {16'd0, ext_src}, {16'd0, e.src});
      chk({tag, "_dst"}, {16'd0, ext_dst}, {16'd0, e.dst});
      chk({tag, "_fmt"}, {30'd0, FORMAT}, {30'd0, e.fmt});
      chk({tag, "_adas"}, {29'd0, AdAs}, {29'd0, e.adas});
      chk({tag, "_next"}, {30'd0, n_ext}, {30'd0, e.n});
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1 chk({tag, "_drop"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; MDB_out = '0; mdb_valid = 1'b0;
    flush = 1'b0; instr_ready = 1'b0;
    mdb1 = '0; v1 = 1'b0; rdy1 = 1'b0;
    #1;
    chk("rst_req", {31'd0, fetch_req}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pcinc", {31'd0, pc_inc}, 32'd0);
    chk("rst_IR", {16'd0, IR}, 32'd0);
    chk("rst_next", {30'd0, n_ext}, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    chk("rst_to", {31'd0, fetch_to}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    push(16'h4405, 16'h0000, 16'h0000, 2'd1, 3'b000, 2'd0);
    send(16'h4405);
    issue("mov_rr");

    push(16'h40B2, 16'h1234, 16'h0200, 2'd1, 3'b111, 2'd2);
    send(16'h40B2);
    send(16'h1234);
    send(16'h0200);
    issue("mov_imm_abs");

    push(16'h5316, 16'h0000, 16'h0000, 2'd1, 3'b001, 2'd0);
    send(16'h5316);
    issue("add_cg");

    push(16'h12B0, 16'h0055, 16'h0000, 2'd2, 3'b011, 2'd1);
    send(16'h12B0);
    send(16'h0055);
    issue("push_imm");

    push(16'h3CB5, 16'h0000, 16'h0000, 2'd3, 3'b000, 2'd0);
    send(16'h3CB5);
    issue("jmp");

    push(16'h4215, 16'hABCD, 16'h0000, 2'd1, 3'b001, 2'd1);
    send(16'h4215);
    send(16'hABCD);
    issue("abs_src");

    // ISSUE holds while decode is not ready; offered words are ignored
    push(16'h4405, 16'h0000, 16'h0000, 2'd1, 3'b000, 2'd0);
    send(16'h4405);
    @(negedge clk);
    MDB_out = 16'h7777;
    #1;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_pcinc", {31'd0, pc_inc}, 32'd0);
    issue("hold");

    send(16'h0000);
    @(negedge clk);
    mdb_valid = 1'b0;
    #1;
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_valid", {31'd0, instr_valid}, 32'd0);
    chk("ill_req", {31'd0, fetch_req}, 32'd1);
    @(negedge clk);
    #1 chk("ill_once", {31'd0, illegal}, 32'd0);

    send(16'h40B2);
    @(negedge clk);
    MDB_out = 16'h9999;
    flush = 1'b1;
    #1 chk("flush_pcinc", {31'd0, pc_inc}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    mdb_valid = 1'b0;
    #1;
    chk("flush_src", {16'd0, ext_src}, 32'd0);
    chk("flush_req", {31'd0, fetch_req}, 32'd1);
    push(16'h4405, 16'h0000, 16'h0000, 2'd1, 3'b000, 2'd0);
    send(16'h4405);
    issue("after_flush");

    send(16'h4405);
    @(negedge clk);
    mdb_valid = 1'b0;
    instr_ready = 1'b1;
    flush = 1'b1;
    #1 chk("fiss_valid", {31'd0, instr_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("fiss_drop", {31'd0, instr_valid}, 32'd0);
    chk("fiss_req", {31'd0, fetch_req}, 32'd1);
    push(16'h42A5, 16'h0000, 16'h5555, 2'd1, 3'b110, 2'd1);
    send(16'h42A5);
    send(16'h5555);
    issue("cg_r2_dst");

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      #1 chk($sformatf("wd_%0d", k), {31'd0, fetch_to},
             {31'd0, (k == 15) || (k == 30)});
    end
    chk("wd_req", {31'd0, fetch_req}, 32'd1);

    @(negedge clk);
    mdb1 = 16'h5316;
    v1 = 1'b1;
    #1 chk("nocg_pc0", {31'd0, pc_inc1}, 32'd1);
    @(negedge clk);
    mdb1 = 16'hAAAA;
    #1 chk("nocg_pc1", {31'd0, pc_inc1}, 32'd1);
    @(negedge clk);
    v1 = 1'b0;
    #1;
    chk("nocg_valid", {31'd0, instr_valid1}, 32'd1);
    chk("nocg_next", {30'd0, n_ext1}, 32'd1);
    chk("nocg_src", {16'd0, ext_src1}, 32'h0000AAAA);
    chk("nocg_adas", {29'd0, AdAs1}, 32'd1);
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;

    send(16'h40B2);
    send(16'h1234);
    @(negedge clk);
    mdb_valid = 1'b0;
    #1;
    chk("mid_next", {30'd0, n_ext}, 32'd1);
    chk("mid_src", {16'd0, ext_src}, 32'h00001234);
    #1 rst = 1'b1;
    #1;
    chk("arst_src", {16'd0, ext_src}, 32'd0);
    chk("arst_next", {30'd0, n_ext}, 32'd0);
    chk("arst_IR", {16'd0, IR}, 32'd0);
    chk("arst_fmt", {30'd0, FORMAT}, 32'd0);
    chk("arst_req", {31'd0, fetch_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
